median_window_feeder: RTL and testbench

//  Upstream stage of the 9-input median filter. Accepts a raster pixel stream
//  and keeps the two previous lines in line buffers. For every pixel at
//  col>=2, row>=2 it serialises the 3x3 window ending at that pixel onto DO/DSO:
//  9 consecutive DSO-high cycles. It then stalls input until the median stage

---
 rtl/median_pkg.sv | 15 +
 rtl/median_window_feeder_line_buffer.sv | 31 +++
 rtl/median_window_feeder.sv | 125 ++++++++++++
 tb/tb_median_window_feeder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared definitions for the median filter pipeline (window feeder + median stage).
//   W_DEF  : default pixel width
//   WIN_N  : pixels per 3x3 window
//   med_state_e : window feeder sequencing states
package median_pkg;
   localparam int W_DEF = 8;
   localparam int WIN_N = 9;

   typedef enum logic [1:0] {
      PREP = 2'd0,
      LOAD = 2'd1,
      EMIT = 2'd2,
      WAIT = 2'd3
   } med_state_e;
endpackage

// File: rtl/median_window_feeder_line_buffer.sv
// line_buffer: one raster line of pixel storage.
// Single-port RAM. Reads are synchronous and only update the output register
// when re is high, so a write on the same address never disturbs the
// previously read value.
//   clk   : clock
//   re    : read enable, rdata <= mem[addr]
//   we    : write enable, mem[addr] <= wdata
//   addr  : column address
//   wdata : write pixel
//   rdata : registered read pixel
module line_buffer #(
   parameter int W      = 8,
   parameter int LINE_W = 640
) (
   input  logic                      clk,
   input  logic                      re,
   input  logic                      we,
   input  logic [$clog2(LINE_W)-1:0] addr,
   input  logic [W-1:0]              wdata,
   output logic [W-1:0]              rdata
);
   logic [W-1:0] mem [LINE_W];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata_q <= mem[addr];
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/median_window_feeder.sv
// median_window_feeder: builds 3x3 windows from a raster pixel stream and
// serialises each one (9 pixels, row-major from top-left) to the median stage,
// then stalls the input until the median stage reports done.
//   CLK, nRST         : clock, synchronous active-low reset
//   PIX_I/PIX_VALID/PIX_READY : pixel input handshake
//   SOF               : marks PIX_I as pixel (row 0, col 0)
//   DO/DSO            : window pixel stream to median stage
//   MED_DONE          : median result strobe, releases the stall
//   COL_O/ROW_O       : centre coordinates of the last emitted window
module median_window_feeder
   import median_pkg::*;
#(
   parameter int W      = W_DEF,
   parameter int LINE_W = 640,
   parameter int ROW_W  = 11
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic [W-1:0]              PIX_I,
   input  logic                      PIX_VALID,
   output logic                      PIX_READY,
   input  logic                      SOF,
   output logic [W-1:0]              DO,
   output logic                      DSO,
   input  logic                      MED_DONE,
   output logic [$clog2(LINE_W)-1:0] COL_O,
   output logic [ROW_W-1:0]          ROW_O
);
   localparam int CW = $clog2(LINE_W);

   med_state_e                state_q, state_d;
   logic [CW-1:0]             col_q, col_d, col_o_q, col_o_d, eff_col, lb_addr;
   logic [ROW_W-1:0]          row_q, row_d, row_o_q, row_o_d, eff_row;
   logic [3:0]                k_q, k_d;
   // win[r*3+c]: r=0 top (oldest line), c=0 oldest column
   logic [WIN_N-1:0][W-1:0]   win_q, win_d;
   logic                      xfer;
   logic [W-1:0]              lb0_rd, lb1_rd;

   assign xfer    = (state_q == LOAD) && PIX_VALID;
   // SOF re-bases the accepted pixel to (0,0) before any use of the counters
   assign eff_col = SOF ? '0 : col_q;
   assign eff_row = SOF ? '0 : row_q;
   // read in PREP at the expected column; write in LOAD at the effective one
   assign lb_addr = (state_q == LOAD) ? eff_col : col_q;

   line_buffer #(.W(W), .LINE_W(LINE_W)) lb0 (
      .clk(CLK), .re(state_q == PREP), .we(xfer), .addr(lb_addr),
      .wdata(PIX_I), .rdata(lb0_rd)
   );
   line_buffer #(.W(W), .LINE_W(LINE_W)) lb1 (
      .clk(CLK), .re(state_q == PREP), .we(xfer), .addr(lb_addr),
      .wdata(lb0_rd), .rdata(lb1_rd)
   );

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      col_o_d = col_o_q;
      row_o_d = row_o_q;
      k_d     = k_q;
      win_d   = win_q;
      case (state_q)
         PREP: state_d = LOAD;
         LOAD: if (xfer) begin
            win_d[0] = win_q[1];  win_d[1] = win_q[2];  win_d[2] = lb1_rd;
            win_d[3] = win_q[4];  win_d[4] = win_q[5];  win_d[5] = lb0_rd;
            win_d[6] = win_q[7];  win_d[7] = win_q[8];  win_d[8] = PIX_I;
            if (eff_col == CW'(LINE_W - 1)) begin
               col_d = '0;
               row_d = (eff_row == '1) ? eff_row : eff_row + ROW_W'(1);
            end else begin
               col_d = eff_col + CW'(1);
               row_d = eff_row;
            end
            if (eff_col >= CW'(2) && eff_row >= ROW_W'(2)) begin
               col_o_d = eff_col - CW'(1);
               row_o_d = eff_row - ROW_W'(1);
               k_d     = '0;
               state_d = EMIT;
            end else begin
               state_d = PREP;
            end
         end
         EMIT: begin
            if (k_q == 4'(WIN_N - 1)) begin
               k_d     = '0;
               state_d = WAIT;
            end else begin
               k_d = k_q + 4'd1;
            end
         end
         WAIT: if (MED_DONE) state_d = PREP;
         default: state_d = PREP;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= PREP;
         col_q   <= '0;
         row_q   <= '0;
         col_o_q <= '0;
         row_o_q <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         col_o_q <= col_o_d;
         row_o_q <= row_o_d;
         k_q     <= k_d;
      end
   end

   // window contents need no reset: they are only emitted after a full 3x3 fill
   always_ff @(posedge CLK) win_q <= win_d;

   assign PIX_READY = (state_q == LOAD);
   assign DSO       = (state_q == EMIT);
   assign DO        = (state_q == EMIT) ? win_q[k_q] : '0;
   assign COL_O     = col_o_q;
   assign ROW_O     = row_o_q;
endmodule

// File: tb/tb_median_window_feeder.sv
module tb_median_window_feeder;
   logic       clk = 1'b0;
   logic       nRST, PIX_VALID, SOF, MED_DONE;
   logic [7:0] PIX_I;
   logic       PIX_READY, DSO;
   logic [7:0] DO;
   logic [1:0] COL_O;
   logic [10:0] ROW_O;

   int n_chk = 0;
   int n_fail = 0;

   median_window_feeder #(.W(8), .LINE_W(4), .ROW_W(11)) dut (
      .CLK(clk), .nRST(nRST), .PIX_I(PIX_I), .PIX_VALID(PIX_VALID),
      .PIX_READY(PIX_READY), .SOF(SOF), .DO(DO), .DSO(DSO),
      .MED_DONE(MED_DONE), .COL_O(COL_O), .ROW_O(ROW_O)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]       pix;
      logic             sof;
      logic             win;
      logic [8:0][7:0]  w;
      logic [1:0]       co;
      logic [10:0]      ro;
   } vec_t;

   vec_t vt [28];
   int   nv = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic logic [8:0][7:0] w9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
      logic [8:0][7:0] r;
      r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2);
      r[3] = 8'(a3); r[4] = 8'(a4); r[5] = 8'(a5);
      r[6] = 8'(a6); r[7] = 8'(a7); r[8] = 8'(a8);
      return r;
   endfunction

   task automatic add(input int pix, input bit sof, input bit win,
                      input logic [8:0][7:0] w, input int co, input int ro);
      vt[nv].pix = 8'(pix); vt[nv].sof = sof; vt[nv].win = win;
      vt[nv].w = w; vt[nv].co = 2'(co); vt[nv].ro = 11'(ro);
      nv++;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // waits (bounded) for PIX_READY, transfers one pixel; returns in cycle t+1
   task automatic push(input logic [7:0] p, input bit sof);
      int n = 0;
      while (PIX_READY !== 1'b1 && n < 50) begin step(); n++; end
      if (PIX_READY !== 1'b1) chk("ready_timeout", {31'd0, PIX_READY}, 32'd1);
      PIX_I = p; PIX_VALID = 1'b1; SOF = sof;
      step();
      PIX_VALID = 1'b0; SOF = 1'b0;
   endtask

   task automatic release_wait();
      MED_DONE = 1'b1; step(); MED_DONE = 1'b0;
      chk("ready_after_done+1", {31'd0, PIX_READY}, 32'd0);
      step();
      chk("ready_after_done+2", {31'd0, PIX_READY}, 32'd1);
   endtask

   task automatic chk_win(input logic [8:0][7:0] w, input int co, input int ro, input int hold);
      for (int k = 0; k < 9; k++) begin
         chk("dso_emit", {31'd0, DSO}, 32'd1);
         chk("do_emit", {24'd0, DO}, {24'd0, w[k]});
         step();
      end
      chk("dso_after9", {31'd0, DSO}, 32'd0);
      chk("col_o", {30'd0, COL_O}, 32'(co));
      chk("row_o", {21'd0, ROW_O}, 32'(ro));
      for (int i = 0; i < hold; i++) begin
         chk("ready_in_wait", {31'd0, PIX_READY}, 32'd0);
         step();
      end
      release_wait();
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [8:0][7:0] wexp;
      bit first = 1'b1;
      nRST = 1'b0; PIX_VALID = 1'b0; SOF = 1'b0; MED_DONE = 1'b0; PIX_I = '0;

      // frame 1 (LINE_W=4, pixel = 10*row+col)
      add(0, 1, 0, '0, 0, 0); add(1, 0, 0, '0, 0, 0); add(2, 0, 0, '0, 0, 0); add(3, 0, 0, '0, 0, 0);
      add(10, 0, 0, '0, 0, 0); add(11, 0, 0, '0, 0, 0); add(12, 0, 0, '0, 0, 0); add(13, 0, 0, '0, 0, 0);
      add(20, 0, 0, '0, 0, 0); add(21, 0, 0, '0, 0, 0);
      add(22, 0, 1, w9(0, 1, 2, 10, 11, 12, 20, 21, 22), 1, 1);
      add(23, 0, 1, w9(1, 2, 3, 11, 12, 13, 21, 22, 23), 2, 1);
      add(30, 0, 0, '0, 0, 0); add(31, 0, 0, '0, 0, 0);
      add(32, 0, 1, w9(10, 11, 12, 20, 21, 22, 30, 31, 32), 1, 2);
      add(33, 0, 1, w9(11, 12, 13, 21, 22, 23, 31, 32, 33), 2, 2);
      // row 4, then SOF mid-line at col 2: must not produce a window
      add(40, 0, 0, '0, 0, 0); add(41, 0, 0, '0, 0, 0);
      add(0, 1, 0, '0, 0, 0); add(1, 0, 0, '0, 0, 0); add(2, 0, 0, '0, 0, 0); add(3, 0, 0, '0, 0, 0);
      add(10, 0, 0, '0, 0, 0); add(11, 0, 0, '0, 0, 0); add(12, 0, 0, '0, 0, 0); add(13, 0, 0, '0, 0, 0);
      add(20, 0, 0, '0, 0, 0); add(21, 0, 0, '0, 0, 0);

      // reset state
      step(); step();
      chk("rst_ready", {31'd0, PIX_READY}, 32'd0);
      chk("rst_dso", {31'd0, DSO}, 32'd0);
      chk("rst_do", {24'd0, DO}, 32'd0);
      chk("rst_col_o", {30'd0, COL_O}, 32'd0);
      chk("rst_row_o", {21'd0, ROW_O}, 32'd0);
      nRST = 1'b1;
      chk("prep_after_rst", {31'd0, PIX_READY}, 32'd0);
      step();
      chk("load_after_rst", {31'd0, PIX_READY}, 32'd1);
      // idle LOAD with PIX_VALID low holds
      step(); step();
      chk("load_hold", {31'd0, PIX_READY}, 32'd1);

      for (int i = 0; i < nv; i++) begin
         push(vt[i].pix, vt[i].sof);
         if (vt[i].win) begin
            chk_win(vt[i].w, int'(vt[i].co), int'(vt[i].ro), first ? 20 : 2);
            first = 1'b0;
         end else begin
            chk("dso_border", {31'd0, DSO}, 32'd0);
            chk("ready_border_t1", {31'd0, PIX_READY}, 32'd0);
            step();
            chk("ready_border_t2", {31'd0, PIX_READY}, 32'd1);
         end
      end

      // frame 2 pixel (2,2): MED_DONE during EMIT is ignored
      push(8'd22, 1'b0);
      wexp = w9(0, 1, 2, 10, 11, 12, 20, 21, 22);
      for (int k = 0; k < 9; k++) begin
         chk("dso_emit_md", {31'd0, DSO}, 32'd1);
         chk("do_emit_md", {24'd0, DO}, {24'd0, wexp[k]});
         MED_DONE = (k == 3);
         step();
      end
      MED_DONE = 1'b0;
      chk("dso_after9_md", {31'd0, DSO}, 32'd0);
      chk("col_o_md", {30'd0, COL_O}, 32'd1);
      chk("row_o_md", {21'd0, ROW_O}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("still_wait_md", {31'd0, PIX_READY}, 32'd0);
         step();
      end
      release_wait();

      // frame 2 pixel (2,3): reset in the middle of EMIT aborts the window
      push(8'd23, 1'b0);
      wexp = w9(1, 2, 3, 11, 12, 13, 21, 22, 23);
      for (int k = 0; k < 4; k++) begin
         chk("do_pre_rst", {24'd0, DO}, {24'd0, wexp[k]});
         step();
      end
      nRST = 1'b0;
      step();
      nRST = 1'b1;
      chk("dso_abort", {31'd0, DSO}, 32'd0);
      chk("ready_abort", {31'd0, PIX_READY}, 32'd0);
      chk("do_abort", {24'd0, DO}, 32'd0);
      chk("col_o_abort", {30'd0, COL_O}, 32'd0);
      chk("row_o_abort", {21'd0, ROW_O}, 32'd0);
      step();
      chk("ready_after_abort", {31'd0, PIX_READY}, 32'd1);
      chk("dso_after_abort", {31'd0, DSO}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
